// File: rtl/seven_seg_scanner.sv
// Double-buffered, multiplexed common-anode seven-segment driver with per-slot
// dead-time, PWM dimming, leading-zero suppression and frame-synchronous updates.
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_CYCLES = 16384,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter int unsigned BRIGHT_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic [NUM_DIGITS-1:0]     blank_i,
    input  logic                      lz_en,
    input  logic                      load,
    input  logic [BRIGHT_WIDTH-1:0]   brightness,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start,
    output logic                      load_ack
);
    localparam int unsigned SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned DW = $clog2(NUM_DIGITS);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_CYCLES - 1);
    localparam logic [SW-1:0] BLANK_L    = SW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    typedef enum logic {PH_BLANK, PH_ON} phase_t;
    localparam phase_t PH_INIT = (BLANK_CYCLES == 0) ? PH_ON : PH_BLANK;

    logic [SW-1:0]           r_slot;
    logic [DW-1:0]           r_digit;
    phase_t                  r_phase;
    logic [BRIGHT_WIDTH-1:0] r_pwm;

    logic [4*NUM_DIGITS-1:0] r_stg_dig, r_disp_dig;
    logic [NUM_DIGITS-1:0]   r_stg_dp, r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_stg_blank, r_disp_blank;
    logic                    r_stg_lz, r_disp_lz;
    logic                    r_pending;
    logic                    r_fresh;

    logic                    w_slot_last, w_boundary, w_frame0;
    logic [SW-1:0]           w_slot_nxt;
    logic [3:0]              w_nib;
    logic                    w_lit, w_active, w_supp;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0: f_decode = 7'b1000000;
            4'h1: f_decode = 7'b1111001;
            4'h2: f_decode = 7'b0100100;
            4'h3: f_decode = 7'b0110000;
            4'h4: f_decode = 7'b0011001;
            4'h5: f_decode = 7'b0010010;
            4'h6: f_decode = 7'b0000010;
            4'h7: f_decode = 7'b1111000;
            4'h8: f_decode = 7'b0000000;
            4'h9: f_decode = 7'b0010000;
            4'hA: f_decode = 7'b0001000;
            4'hB: f_decode = 7'b0000011;
            4'hC: f_decode = 7'b1000110;
            4'hD: f_decode = 7'b0100001;
            4'hE: f_decode = 7'b0000110;
            default: f_decode = 7'b0001110;
        endcase
    endfunction

    assign w_slot_last = (r_slot == SLOT_LAST);
    assign w_boundary  = w_slot_last && (r_digit == DIGIT_LAST);
    assign w_frame0    = (r_slot == '0) && (r_digit == '0);
    assign w_slot_nxt  = w_slot_last ? '0 : r_slot + 1'b1;
    assign w_nib       = r_disp_dig[{r_digit, 2'b00} +: 4];
    assign w_lit       = (&brightness) || (r_pwm < brightness);
    assign w_active    = (r_phase == PH_ON) && !r_disp_blank[r_digit] && w_lit;
    // Digit 0 is never suppressed; higher digits go dark when they and all above are zero
    assign w_supp      = r_disp_lz && (r_digit != '0) && ((r_disp_dig >> {r_digit, 2'b00}) == '0);

    always_comb begin
        w_an_nxt = '1;
        if (w_active) w_an_nxt[r_digit] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_digit <= '0;
            r_phase <= PH_INIT;
            r_pwm   <= '0;
        end else begin
            r_slot  <= w_slot_nxt;
            if (w_slot_last) r_digit <= (r_digit == DIGIT_LAST) ? '0 : r_digit + 1'b1;
            r_phase <= (w_slot_nxt < BLANK_L) ? PH_BLANK : PH_ON;
            r_pwm   <= (w_slot_nxt == BLANK_L) ? '0 : r_pwm + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_dig    <= '0;
            r_stg_dp     <= '0;
            r_stg_blank  <= '1;
            r_stg_lz     <= 1'b0;
            r_disp_dig   <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '1;
            r_disp_lz    <= 1'b0;
            r_pending    <= 1'b0;
            r_fresh      <= 1'b0;
        end else begin
            if (load) begin
                r_stg_dig   <= digits_i;
                r_stg_dp    <= dp_i;
                r_stg_blank <= blank_i;
                r_stg_lz    <= lz_en;
            end
            // A load landing on the boundary bypasses staging straight into display
            if (w_boundary) begin
                r_pending <= 1'b0;
                r_fresh   <= r_pending || load;
                if (load) begin
                    r_disp_dig   <= digits_i;
                    r_disp_dp    <= dp_i;
                    r_disp_blank <= blank_i;
                    r_disp_lz    <= lz_en;
                end else if (r_pending) begin
                    r_disp_dig   <= r_stg_dig;
                    r_disp_dp    <= r_stg_dp;
                    r_disp_blank <= r_stg_blank;
                    r_disp_lz    <= r_stg_lz;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            an          <= w_an_nxt;
            seg         <= (w_active && !w_supp) ? f_decode(w_nib) : 7'h7F;
            dp          <= w_active ? ~r_disp_dp[r_digit] : 1'b1;
            frame_start <= w_frame0;
            load_ack    <= w_frame0 && r_fresh;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised and directed bench for seven_seg_scanner, checked against a
// position-arithmetic model of the scan sequence.
module tb_seven_seg_scanner;
    localparam int N  = 4;
    localparam int DC = 32;
    localparam int BC = 4;
    localparam int FR = N * DC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_start, load_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BRIGHT_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i), .blank_i(blank_i),
        .lz_en(lz_en), .load(load), .brightness(brightness), .an(an), .seg(seg), .dp(dp),
        .frame_start(frame_start), .load_ack(load_ack)
    );

    logic [6:0] dec_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: everything is derived from m_cnt, the number of clock edges since reset
    int          m_cnt;
    logic [15:0] m_sd, m_dd;
    logic [3:0]  m_sdp, m_ddp, m_sbl, m_dbl;
    logic        m_slz, m_dlz, m_pend, m_fresh;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs, e_ack;

    int   m_pos, m_slot, m_dig;
    logic m_act, m_sup;
    assign m_pos  = m_cnt % FR;
    assign m_slot = m_pos % DC;
    assign m_dig  = m_pos / DC;
    assign m_act  = (m_slot >= BC) && !m_dbl[m_dig] &&
                    (brightness == 4'hF || ((m_slot - BC) % 16) < int'(brightness));
    assign m_sup  = m_dlz && (m_dig >= 1) && ((m_dd >> (4 * m_dig)) == 16'h0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_sd <= '0; m_dd <= '0; m_sdp <= '0; m_ddp <= '0;
            m_sbl <= '1; m_dbl <= '1; m_slz <= 1'b0; m_dlz <= 1'b0;
            m_pend <= 1'b0; m_fresh <= 1'b0;
            e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0; e_ack <= 1'b0;
        end else begin
            e_an  <= m_act ? ~(4'b0001 << m_dig) : 4'hF;
            e_seg <= (m_act && !m_sup) ? dec_tab[m_dd[4*m_dig +: 4]] : 7'h7F;
            e_dp  <= m_act ? ~m_ddp[m_dig] : 1'b1;
            e_fs  <= (m_pos == 0);
            e_ack <= (m_pos == 0) && m_fresh;
            if (load) begin
                m_sd <= digits_i; m_sdp <= dp_i; m_sbl <= blank_i; m_slz <= lz_en;
                m_pend <= 1'b1;
            end
            if (m_pos == FR - 1) begin
                m_fresh <= m_pend || load;
                m_pend  <= 1'b0;
                if (load) begin
                    m_dd <= digits_i; m_ddp <= dp_i; m_dbl <= blank_i; m_dlz <= lz_en;
                end else if (m_pend) begin
                    m_dd <= m_sd; m_ddp <= m_sdp; m_dbl <= m_sbl; m_dlz <= m_slz;
                end
            end
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic lz);
        digits_i = d; dp_i = p; blank_i = b; lz_en = lz; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * FR; i++) begin
            step();
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst_n = 1'b0;
        #23;
        n_tests++;
        if ({an, seg, dp, frame_start, load_ack} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals: got an=%b seg=%b dp=%b fs=%b ack=%b", an, seg, dp, frame_start, load_ack);
        end
        @(posedge clk); #2; rst_n = 1'b1;
        step();
        n_tests++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fs: got %b want 1", frame_start);
        end
        pulses = 0;
        for (int i = 1; i <= FR; i++) begin
            step();
            if (frame_start === 1'b1) pulses++;
            n_tests++;
            if ({an, seg, dp, frame_start, load_ack} !== {e_an, e_seg, e_dp, e_fs, e_ack} || an !== 4'hF) begin
                n_fail++;
                $display("FAIL reset_dark c%0d: got an=%b seg=%b dp=%b fs=%b ack=%b want an=%b seg=%b dp=%b fs=%b ack=%b",
                         i, an, seg, dp, frame_start, load_ack, e_an, e_seg, e_dp, e_fs, e_ack);
            end
        end
        n_tests++;
        if (pulses != 1 || frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL fs_period: got %0d pulses (fs now %b) want 1 pulse at cycle %0d", pulses, frame_start, FR);
        end
    endtask

    task automatic test_hex_display();
        bit ok;
        brightness = 4'hF;
        do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
        wait_fs(ok);
        n_tests++;
        if (!ok || load_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL hex_ack: got found=%0d ack=%b want found=1 ack=1", ok, load_ack);
        end
        for (int off = 1; off < FR; off++) begin
            step();
            n_tests++;
            if ({an, seg, dp, frame_start, load_ack} !== {e_an, e_seg, e_dp, e_fs, e_ack}) begin
                n_fail++;
                $display("FAIL hex_model o%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", off, an, seg, dp, e_an, e_seg, e_dp);
            end
            if ((off % DC) < BC) begin
                n_tests++;
                if (an !== 4'hF) begin n_fail++; $display("FAIL hex_deadtime o%0d: got an=%b want 1111", off, an); end
            end
            if (off == 10) begin
                n_tests++;
                if (an !== 4'b1110 || seg !== 7'b0001110) begin
                    n_fail++; $display("FAIL hex_d0: got an=%b seg=%b want 1110 0001110", an, seg);
                end
            end
            if (off == 3 * DC + 10) begin
                n_tests++;
                if (an !== 4'b0111 || seg !== 7'b1111001) begin
                    n_fail++; $display("FAIL hex_d3: got an=%b seg=%b want 0111 1111001", an, seg);
                end
            end
        end
    endtask

    task automatic test_lz();
        bit ok;
        do_load(16'h0050, 4'b0100, 4'h0, 1'b1);
        wait_fs(ok);
        for (int off = 1; off < FR; off++) begin
            step();
            n_tests++;
            if ({an, seg, dp, frame_start, load_ack} !== {e_an, e_seg, e_dp, e_fs, e_ack}) begin
                n_fail++;
                $display("FAIL lz_model o%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", off, an, seg, dp, e_an, e_seg, e_dp);
            end
            if (off == 10 && seg !== 7'b1000000) begin n_fail++; $display("FAIL lz_d0: got seg=%b want 1000000", seg); end
            if (off == DC + 10 && seg !== 7'b0010010) begin n_fail++; $display("FAIL lz_d1: got seg=%b want 0010010", seg); end
            if (off == 2*DC + 10 && {an, seg, dp} !== {4'b1011, 7'h7F, 1'b0}) begin
                n_fail++; $display("FAIL lz_d2: got an=%b seg=%b dp=%b want 1011 1111111 0", an, seg, dp);
            end
            if (off == 3*DC + 10 && {seg, dp} !== {7'h7F, 1'b1}) begin
                n_fail++; $display("FAIL lz_d3: got seg=%b dp=%b want 1111111 1", seg, dp);
            end
            if (off == 10 || off == DC + 10 || off == 2*DC + 10 || off == 3*DC + 10) n_tests++;
        end
        do_load(16'h0000, 4'h0, 4'h0, 1'b1);
        wait_fs(ok);
        for (int off = 1; off < FR; off++) begin
            step();
            n_tests++;
            if ((off % DC) == 10 && off != 10 && seg !== 7'h7F) begin
                n_fail++; $display("FAIL lz_zero_hi o%0d: got seg=%b want 1111111", off, seg);
            end else if (off == 10 && {an, seg} !== {4'b1110, 7'b1000000}) begin
                n_fail++; $display("FAIL lz_zero_d0: got an=%b seg=%b want 1110 1000000", an, seg);
            end else if ({an, seg, dp, frame_start, load_ack} !== {e_an, e_seg, e_dp, e_fs, e_ack}) begin
                n_fail++;
                $display("FAIL lz0_model o%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", off, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
    endtask

    task automatic test_brightness();
        bit ok;
        int lit;
        do_load(16'h8888, 4'h0, 4'h0, 1'b0);
        wait_fs(ok);
        brightness = 4'd4;
        lit = 0;
        for (int off = 1; off < DC; off++) begin
            step();
            if (an !== 4'hF) lit++;
            n_tests++;
            if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
                n_fail++; $display("FAIL pwm_model o%0d: got an=%b seg=%b want an=%b seg=%b", off, an, seg, e_an, e_seg);
            end
        end
        n_tests++;
        if (lit != 8) begin n_fail++; $display("FAIL pwm4_count: got %0d lit cycles want 8", lit); end
        brightness = 4'd0;
        lit = 0;
        for (int i = 0; i < FR; i++) begin
            step();
            if (an !== 4'hF) lit++;
        end
        n_tests++;
        if (lit != 0) begin n_fail++; $display("FAIL pwm0_dark: got %0d lit cycles want 0", lit); end
        brightness = 4'hF;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int guard;
        guard = 0;
        while ((m_cnt % FR) != DC + 2 && guard < 2 * FR) begin step(); guard++; end
        do_load(16'h1111, 4'h0, 4'h0, 1'b0);
        while ((m_cnt % FR) != DC + 16 && guard < 4 * FR) begin step(); guard++; end
        n_tests++;
        if ({an, seg} !== {4'b1101, 7'h00}) begin
            n_fail++; $display("FAIL b2b_hold: got an=%b seg=%b want 1101 0000000", an, seg);
        end
        do_load(16'h2222, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 2 * DC; i++) begin
            step();
            n_tests++;
            if ({an, seg, dp, frame_start, load_ack} !== {e_an, e_seg, e_dp, e_fs, e_ack}) begin
                n_fail++; $display("FAIL b2b_model c%0d: got an=%b seg=%b ack=%b want an=%b seg=%b ack=%b", i, an, seg, load_ack, e_an, e_seg, e_ack);
            end
            if (frame_start === 1'b1) break;
        end
        if (frame_start !== 1'b1) wait_fs(ok);
        n_tests++;
        if (frame_start !== 1'b1 || load_ack !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ack: got fs=%b ack=%b want 1 1", frame_start, load_ack);
        end
        repeat (10) step();
        n_tests++;
        if ({an, seg} !== {4'b1110, 7'b0100100}) begin
            n_fail++; $display("FAIL b2b_last_wins: got an=%b seg=%b want 1110 0100100", an, seg);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                digits_i = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
                dp_i     = 4'($urandom);
                blank_i  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                lz_en    = 1'($urandom);
                load     = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
            step();
            load = 1'b0;
            n_tests++;
            if ({an, seg, dp, frame_start, load_ack} !== {e_an, e_seg, e_dp, e_fs, e_ack}) begin
                n_fail++;
                $display("FAIL rand c%0d: got an=%b seg=%b dp=%b fs=%b ack=%b want an=%b seg=%b dp=%b fs=%b ack=%b",
                         i, an, seg, dp, frame_start, load_ack, e_an, e_seg, e_dp, e_fs, e_ack);
            end
        end
        brightness = 4'hF;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int guard;
        do_load(16'h4321, 4'h0, 4'h0, 1'b0);
        wait_fs(ok);
        guard = 0;
        while ((m_cnt % FR) != 12 && guard < 2 * FR) begin step(); guard++; end
        n_tests++;
        if (an !== 4'b1110) begin n_fail++; $display("FAIL pre_rst_lit: got an=%b want 1110", an); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({an, seg, dp, frame_start, load_ack} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL async_rst: got an=%b seg=%b dp=%b fs=%b ack=%b", an, seg, dp, frame_start, load_ack);
        end
        @(posedge clk); #2; rst_n = 1'b1;
        for (int i = 0; i < FR + 4; i++) begin
            step();
            n_tests++;
            if ({an, seg, dp, frame_start, load_ack} !== {e_an, e_seg, e_dp, e_fs, e_ack} || an !== 4'hF) begin
                n_fail++; $display("FAIL post_rst_dark c%0d: got an=%b seg=%b fs=%b want an=1111 seg=%b fs=%b", i, an, seg, frame_start, e_seg, e_fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex_display();
        test_lz();
        test_brightness();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
